rx_buffer_drain_scheduler: RTL

Sequences readout of the 512 x 64-bit receive packet buffer that the MAC receive writer fills. It runs in the 250 MHz host clock domain. Its jobs:
- Track the writer's committed address.
- Fetch each packet's header word and validate its length.
- Issue one DMA descriptor per packet, gated by host-ring credits.
- Share the buffer read port with the DMA engine.
- Return freed space to the writer through `rd_addr_extended`.

---
 rtl/rx_buffer_drain_scheduler_if.sv | 37 +++
 rtl/rx_buffer_drain_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rx_buffer_drain_scheduler_if.sv
// Buffer read port and DMA descriptor/transfer signals shared between the
// drain scheduler (master) and the buffer/DMA side (slave).
interface rx_buffer_drain_scheduler_if;
  logic [8:0]  rd_addr;
  logic [63:0] rd_data;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_start_addr;
  logic [15:0] req_byte_count;
  logic [9:0]  req_qwords;
  logic [8:0]  dma_rd_addr;
  logic        dma_done;

  modport master (
    output rd_addr,
    output req_valid,
    output req_start_addr,
    output req_byte_count,
    output req_qwords,
    input  rd_data,
    input  req_ready,
    input  dma_rd_addr,
    input  dma_done
  );

  modport slave (
    input  rd_addr,
    input  req_valid,
    input  req_start_addr,
    input  req_byte_count,
    input  req_qwords,
    output rd_data,
    output req_ready,
    output dma_rd_addr,
    output dma_done
  );
endinterface

// File: rtl/rx_buffer_drain_scheduler.sv
// Receive buffer drain scheduler: walks packets in the 512 x 64 receive
// buffer, validates each header length, issues one DMA descriptor per packet
// (gated by host ring credits) and releases consumed space to the writer.
// Optional build macro: RX_DROP_STATS_EN enables the length-drop counter;
// without it dropped_count is tied to zero.
module rx_buffer_drain_scheduler #(
  parameter int unsigned CREDIT_MAX = 16,
  parameter int unsigned MAX_BYTES  = 1518
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [9:0]                        commited_wr_address,
  output logic [9:0]                        rd_addr_extended,
  input  logic                              credit_return,
  output logic [31:0]                       dropped_count,
  rx_buffer_drain_scheduler_if.master       bus
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StCheck,
    StReq,
    StXfer,
    StRelease
  } state_e;

  localparam logic [7:0]  CreditMax = 8'(CREDIT_MAX);
  localparam logic [31:0] MaxBytes  = 32'(MAX_BYTES);

  state_e      state_q;
  logic [9:0]  commit_s1_q;
  logic [9:0]  commit_s2_q;
  logic [9:0]  commit_sync_q;
  logic [9:0]  rd_ptr_q;
  logic [9:0]  rd_addr_ext_q;
  logic [9:0]  qw_q;
  logic [7:0]  credits_q;
  logic        req_valid_q;
  logic [9:0]  req_start_addr_q;
  logic [15:0] req_byte_count_q;
  logic [9:0]  req_qwords_q;

  logic [31:0] hdr_bc;
  logic [32:0] bc_sum;
  logic [9:0]  hdr_qw;
  logic        hdr_bad;
  logic        buf_empty;
  logic        handshake;
  logic        drop_evt;
  logic        unused_bits;

  assign hdr_bc    = bus.rd_data[63:32];
  assign bc_sum    = {1'b0, hdr_bc} + 33'd7;
  // ceil(bc/8), kept modulo 1024 like all extended-address arithmetic
  assign hdr_qw    = bc_sum[12:3];
  assign hdr_bad   = (hdr_bc == 32'd0) || (hdr_bc > MaxBytes);
  assign buf_empty = (commit_sync_q == rd_ptr_q);
  assign handshake = req_valid_q && bus.req_ready;
  assign drop_evt  = (state_q == StCheck) && hdr_bad;

  assign unused_bits = ^{bus.rd_data[31:0], bc_sum[32:13], bc_sum[2:0]};

  // Read port belongs to the DMA engine only while a payload is moving
  assign bus.rd_addr        = (state_q == StXfer) ? bus.dma_rd_addr : rd_ptr_q[8:0];
  assign bus.req_valid      = req_valid_q;
  assign bus.req_start_addr = req_start_addr_q;
  assign bus.req_byte_count = req_byte_count_q;
  assign bus.req_qwords     = req_qwords_q;
  assign rd_addr_extended   = rd_addr_ext_q;

  // Two-flop capture; commit_sync only takes a value seen on two consecutive
  // samples so skewed multi-bit transitions never leak through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_s1_q   <= '0;
      commit_s2_q   <= '0;
      commit_sync_q <= '0;
    end else begin
      commit_s1_q <= commited_wr_address;
      commit_s2_q <= commit_s1_q;
      if (commit_s1_q == commit_s2_q) begin
        commit_sync_q <= commit_s1_q;
      end
    end
  end

  // Host ring credits: consume on handshake, saturating return; both at once cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= CreditMax;
    end else if (handshake && !credit_return) begin
      credits_q <= credits_q - 8'd1;
    end else if (!handshake && credit_return && (credits_q != CreditMax)) begin
      credits_q <= credits_q + 8'd1;
    end
  end

  // Packet sequencing FSM with registered descriptor and release pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      rd_ptr_q         <= '0;
      rd_addr_ext_q    <= '0;
      qw_q             <= '0;
      req_valid_q      <= 1'b0;
      req_start_addr_q <= '0;
      req_byte_count_q <= '0;
      req_qwords_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!buf_empty) state_q <= StHdr;
        end
        StHdr: begin
          state_q <= StCheck;
        end
        StCheck: begin
          qw_q <= hdr_qw;
          if (hdr_bad) begin
            state_q <= StRelease;
          end else if (credits_q != 8'd0) begin
            state_q          <= StReq;
            req_valid_q      <= 1'b1;
            req_start_addr_q <= rd_ptr_q + 10'd1;
            req_byte_count_q <= hdr_bc[15:0];
            req_qwords_q     <= hdr_qw;
          end
        end
        StReq: begin
          if (bus.req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StXfer;
          end
        end
        StXfer: begin
          if (bus.dma_done) state_q <= StRelease;
        end
        StRelease: begin
          rd_ptr_q      <= rd_ptr_q + 10'd1 + qw_q;
          rd_addr_ext_q <= rd_ptr_q + 10'd1 + qw_q;
          state_q       <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef RX_DROP_STATS_EN
  logic [31:0] drop_cnt_q;

  // Count length-rejected frames, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (drop_evt) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign dropped_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop   = drop_evt;
  assign dropped_count = '0;
`endif

endmodule
